// File: rtl/axi4bus_pkg.sv
// Shared AXI4 bus-link definitions: channel field widths, packed R bundle width,
// response codes and the occupancy encoding used by the register slices.
package axi4bus_pkg;

   localparam int ID_W    = 8;
   localparam int DATA_W  = 64;
   localparam int USER_W  = 4;
   localparam int RESP_W  = 2;
   localparam int R_PKT_W = ID_W + DATA_W + RESP_W + USER_W + 1;

   typedef enum logic [RESP_W-1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi_resp_e;

   // Slice occupancy doubles as the slice state and is exported as LEVEL.
   localparam logic [1:0] LVL_EMPTY = 2'd0;
   localparam logic [1:0] LVL_BUSY  = 2'd1;
   localparam logic [1:0] LVL_FULL  = 2'd2;

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry register slice: fully registered valid, ready and data with
// 1 beat/cycle throughput; reused by every channel combiner of the link.
module axi_skid_buffer
   import axi4bus_pkg::*;
#(
   parameter int WIDTH = R_PKT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       level
);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             in_hs;
   logic             out_hs;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   always_comb begin
      state_next     = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         LVL_EMPTY: begin
            if (in_hs) begin
               state_next = LVL_BUSY;
               load_main  = 1'b1;
            end
         end
         LVL_BUSY: begin
            if (in_hs && !out_hs) begin
               state_next = LVL_FULL;
               load_skid  = 1'b1;
            end else if (out_hs && !in_hs) begin
               state_next = LVL_EMPTY;
            end else if (in_hs && out_hs) begin
               load_main = 1'b1;
            end
         end
         LVL_FULL: begin
            // in_ready is low here, so only the drain of main can happen.
            if (out_hs) begin
               state_next     = LVL_BUSY;
               main_from_skid = 1'b1;
            end
         end
         default: state_next = LVL_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LVL_EMPTY;
         main_data <= '0;
         skid_data <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next != LVL_FULL);
         out_valid <= (state_next != LVL_EMPTY);
         if (load_main) begin
            main_data <= in_data;
         end else if (main_from_skid) begin
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_data <= in_data;
         end
      end
   end

   assign out_data = main_data;
   assign level    = state;

endmodule

// File: rtl/r_backward_combiner.sv
// Slave-side R channel packer: concatenates the discrete R signals into one
// bundle behind a skid buffer and tracks whether an output burst is open.
module r_backward_combiner #(
   parameter  int ID_W   = axi4bus_pkg::ID_W,
   parameter  int DATA_W = axi4bus_pkg::DATA_W,
   parameter  int USER_W = axi4bus_pkg::USER_W,
   localparam int PKT_W  = ID_W + DATA_W + axi4bus_pkg::RESP_W + USER_W + 1
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ID_W-1:0]                RID,
   input  logic [DATA_W-1:0]              RDATA,
   input  logic [axi4bus_pkg::RESP_W-1:0] RRESP,
   input  logic [USER_W-1:0]              RUSER,
   input  logic                           RLAST,
   input  logic                           RVALID,
   output logic                           RREADY,
   output logic [PKT_W-1:0]               DATA,
   output logic                           VALID,
   input  logic                           READY,
   output logic [1:0]                     LEVEL,
   output logic                           IN_BURST
);

   logic [PKT_W-1:0] packed_beat;

   assign packed_beat = {RID, RDATA, RRESP, RUSER, RLAST};

   axi_skid_buffer #(
      .WIDTH(PKT_W)
   ) u_slice (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .in_data  (packed_beat),
      .in_valid (RVALID),
      .in_ready (RREADY),
      .out_data (DATA),
      .out_valid(VALID),
      .out_ready(READY),
      .level    (LEVEL)
   );

   // RLAST sits at bit 0 of the bundle, so the beat leaving decides burst state.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         IN_BURST <= 1'b0;
      end else if (VALID && READY) begin
         IN_BURST <= !DATA[0];
      end
   end

endmodule

// File: tb/tb_r_backward_combiner.sv
// Self-checking bench for r_backward_combiner: directed scenarios plus random
// stalls, checked against a 2-deep FIFO scoreboard of accepted beats.
module tb_r_backward_combiner;

   localparam int ID_W   = 8;
   localparam int DATA_W = 64;
   localparam int USER_W = 4;
   localparam int PKT_W  = ID_W + DATA_W + 2 + USER_W + 1;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b1;
   logic [ID_W-1:0]   RID = '0;
   logic [DATA_W-1:0] RDATA = '0;
   logic [1:0]        RRESP = '0;
   logic [USER_W-1:0] RUSER = '0;
   logic              RLAST = 1'b0;
   logic              RVALID = 1'b0;
   logic              RREADY;
   logic [PKT_W-1:0]  DATA;
   logic              VALID;
   logic              READY = 1'b0;
   logic [1:0]        LEVEL;
   logic              IN_BURST;

   int vectorCount = 0;
   int missCount   = 0;
   int validPct    = 100;
   int readyPct    = 100;

   logic [PKT_W-1:0] srcQ[$];
   logic [PKT_W-1:0] modelQ[$];
   logic             expInBurst  = 1'b0;
   logic             acceptedNow = 1'b0;
   logic             seenEdge    = 1'b0;

   r_backward_combiner dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .RID     (RID),
      .RDATA   (RDATA),
      .RRESP   (RRESP),
      .RUSER   (RUSER),
      .RLAST   (RLAST),
      .RVALID  (RVALID),
      .RREADY  (RREADY),
      .DATA    (DATA),
      .VALID   (VALID),
      .READY   (READY),
      .LEVEL   (LEVEL),
      .IN_BURST(IN_BURST)
   );

   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [PKT_W-1:0] randBeat(input logic last);
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic [USER_W-1:0] user;
      id   = ID_W'($urandom);
      data = {$urandom, $urandom};
      resp = 2'($urandom);
      user = USER_W'($urandom);
      return {id, data, resp, user, last};
   endfunction

   // One cycle of source/sink behaviour, applied 1 time unit after the edge.
   task automatic applyStimulus();
      @(posedge ACLK);
      #1;
      if (acceptedNow && srcQ.size() > 0) void'(srcQ.pop_front());
      if (RVALID && !acceptedNow && srcQ.size() > 0) begin
         RVALID = 1'b1;
      end else if (srcQ.size() > 0 && int'($urandom_range(99)) < validPct) begin
         {RID, RDATA, RRESP, RUSER, RLAST} = srcQ[0];
         RVALID = 1'b1;
      end else begin
         RVALID = 1'b0;
      end
      READY = (int'($urandom_range(99)) < readyPct);
   endtask

   task automatic waitDrain(input int maxCycles);
      int c = 0;
      while ((srcQ.size() > 0 || modelQ.size() > 0 || RVALID) && c < maxCycles) begin
         applyStimulus();
         c++;
      end
      checkOutput("drain", {126'b0, srcQ.size() == 0, modelQ.size() == 0}, 128'd3);
   endtask

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) seenEdge <= 1'b0;
      else          seenEdge <= 1'b1;
   end

   // Scoreboard: the design behaves as a FIFO of depth two whose head is DATA.
   always @(negedge ACLK) begin
      logic expRready;
      logic inHs;
      logic outHs;
      if (!ARESETN) begin
         checkOutput("rst_valid", VALID, 0);
         checkOutput("rst_rready", RREADY, 0);
         checkOutput("rst_level", LEVEL, 0);
         checkOutput("rst_in_burst", IN_BURST, 0);
         checkOutput("rst_data", DATA, 0);
         modelQ.delete();
         expInBurst  = 1'b0;
         acceptedNow = 1'b0;
      end else begin
         expRready = seenEdge && (modelQ.size() < 2);
         checkOutput("rready", RREADY, expRready);
         checkOutput("valid", VALID, modelQ.size() > 0);
         checkOutput("level", LEVEL, modelQ.size());
         checkOutput("in_burst", IN_BURST, expInBurst);
         if (modelQ.size() > 0) checkOutput("data", DATA, modelQ[0]);
         inHs  = RVALID && expRready;
         outHs = (modelQ.size() > 0) && READY;
         if (outHs) begin
            expInBurst = !modelQ[0][0];
            void'(modelQ.pop_front());
         end
         if (inHs) modelQ.push_back({RID, RDATA, RRESP, RUSER, RLAST});
         acceptedNow = inHs;
      end
   end

   initial begin
      logic [PKT_W-1:0] bpBeat[4];
      logic [PKT_W-1:0] fieldBeat;
      int k;

      // Reset with a beat offered by the slave.
      #1;
      ARESETN = 1'b0;
      RVALID  = 1'b1;
      RID     = 8'h3C;
      RDATA   = 64'hDEAD_BEEF_0000_0001;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      RVALID  = 1'b0;
      #3;
      checkOutput("rready_pre_edge", RREADY, 0);
      applyStimulus();
      #3;
      checkOutput("rready_release", RREADY, 1);

      // Field mapping.
      validPct  = 100;
      readyPct  = 100;
      fieldBeat = {8'hA5, 64'h0123_4567_89AB_CDEF, 2'd2, 4'h9, 1'b1};
      srcQ.push_back(fieldBeat);
      applyStimulus();
      applyStimulus();
      #3;
      checkOutput("map_valid", VALID, 1);
      checkOutput("map_data", DATA, 79'h52_8091A2B3C4D5E6F7_D3);
      waitDrain(50);

      // Backpressure.
      readyPct = 0;
      for (int i = 0; i < 4; i++) begin
         bpBeat[i] = {8'(i + 1), 64'(64'h1111 * (i + 1)), 2'd0, 4'(i), i == 3};
         srcQ.push_back(bpBeat[i]);
      end
      repeat (8) applyStimulus();
      #3;
      checkOutput("bp_level", LEVEL, 2);
      checkOutput("bp_rready", RREADY, 0);
      checkOutput("bp_valid", VALID, 1);
      checkOutput("bp_hold", DATA, bpBeat[0]);
      readyPct = 100;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         #3;
         checkOutput("bp_stream_valid", VALID, 1);
         checkOutput("bp_stream_data", DATA, bpBeat[i]);
      end
      waitDrain(50);

      // Full-throughput 16-beat burst.
      for (int i = 0; i < 16; i++) srcQ.push_back(randBeat(i == 15));
      k = 0;
      while (k < 10 && !VALID) begin
         applyStimulus();
         #3;
         k++;
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            applyStimulus();
            #3;
         end
         checkOutput("tp_valid", VALID, 1);
         checkOutput("tp_level", (LEVEL <= 2'd1), 1);
         checkOutput("tp_rready", RREADY, 1);
         checkOutput("tp_in_burst", IN_BURST, i > 0);
      end
      applyStimulus();
      #3;
      checkOutput("tp_end_in_burst", IN_BURST, 0);
      checkOutput("tp_end_valid", VALID, 0);

      // Random stalls.
      validPct = 70;
      readyPct = 70;
      for (int i = 0; i < 10000; i++) srcQ.push_back(randBeat(($urandom % 4) == 0));
      waitDrain(60000);

      // Mid-burst asynchronous reset.
      validPct = 100;
      readyPct = 100;
      for (int i = 0; i < 6; i++) srcQ.push_back(randBeat(i == 5));
      k = 0;
      while (k < 20 && !IN_BURST) begin
         applyStimulus();
         #3;
         k++;
      end
      readyPct = 0;
      repeat (6) applyStimulus();
      #3;
      checkOutput("mid_level", LEVEL, 2);
      checkOutput("mid_in_burst", IN_BURST, 1);
      ARESETN = 1'b0;
      srcQ.delete();
      RVALID = 1'b0;
      #1;
      checkOutput("async_valid", VALID, 0);
      checkOutput("async_level", LEVEL, 0);
      checkOutput("async_in_burst", IN_BURST, 0);
      repeat (3) applyStimulus();
      ARESETN  = 1'b1;
      readyPct = 100;
      repeat (6) applyStimulus();
      #3;
      checkOutput("post_rst_valid", VALID, 0);
      checkOutput("post_rst_level", LEVEL, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
